// File: rtl/leb128_u64_stream_dec.sv
// Byte-serial LEB128 unsigned decoder: accumulates up to ten 7-bit chunks into a u64
// and emits one value per word. Define LEB128_U64_ERR_EN for overflow/too-long detection.
module leb128_u64_stream_dec (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] o,
    output logic [3:0]  len,
    output logic        err,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [63:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] o_q, o_d;
    logic [3:0]  len_q, len_d;
    logic        out_valid_q, out_valid_d;

    logic        accept;
    logic        glue;
    logic [6:0]  chunk;
    logic [5:0]  shamt;
    logic        last_idx;
    logic [63:0] acc_base;
    logic [63:0] acc_next;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign glue     = in_data[7];
    assign chunk    = in_data[6:0];
    assign last_idx = (cnt_q == 4'd9);

    // Index 9 shifts by 63, so only chunk bit 0 lands in acc; bits 6:1 fall off the top.
    assign shamt    = 6'(cnt_q) * 6'd7;
    assign acc_base = (cnt_q == 4'd0) ? 64'd0 : acc_q;
    assign acc_next = acc_base | ({57'd0, chunk} << shamt);

`ifdef LEB128_U64_ERR_EN
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_SKIP    = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   ovf_q, ovf_d;
    logic   err_q, err_d;
    logic   ovf_next;

    assign ovf_next = ovf_q | (last_idx && (|chunk[6:1]));
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

    // NOTE: every variable gets its hold value before any branch, so no path can infer a latch.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        o_d         = o_q;
        len_d       = len_q;
        out_valid_d = out_valid_q && !out_ready;
`ifdef LEB128_U64_ERR_EN
        state_d     = state_q;
        ovf_d       = ovf_q;
        err_d       = err_q;

        if (accept) begin
            if (state_q == ST_SKIP) begin
                if (!glue) begin
                    o_d         = acc_q;
                    len_d       = 4'd10;
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_COLLECT;
                end
            end else if (!glue) begin
                acc_d       = acc_next;
                o_d         = acc_next;
                len_d       = cnt_q + 4'd1;
                err_d       = ovf_next;
                out_valid_d = 1'b1;
                cnt_d       = 4'd0;
                ovf_d       = 1'b0;
            end else if (last_idx) begin
                // Too long: keep the first 64 bits and discard until the word ends.
                acc_d   = acc_next;
                cnt_d   = 4'd0;
                ovf_d   = 1'b0;
                state_d = ST_SKIP;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + 4'd1;
                ovf_d = ovf_next;
            end
        end
`else
        if (accept) begin
            acc_d = acc_next;
            if (!glue || last_idx) begin
                o_d         = acc_next;
                len_d       = cnt_q + 4'd1;
                out_valid_d = 1'b1;
                cnt_d       = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= 64'd0;
            cnt_q       <= 4'd0;
            o_q         <= 64'd0;
            len_q       <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            o_q         <= o_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef LEB128_U64_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_COLLECT;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end
`endif

    assign o         = o_q;
    assign len       = len_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/leb128_u64_stream_dec.md
# leb128_u64_stream_dec

Streaming LEB128 unsigned decoder controller. It accepts an encoded byte stream one byte per cycle over a valid/ready handshake and accumulates up to 10 chunks into a 64-bit value. It emits one decoded value per LEB128 word, with its byte length and an error flag, on a second valid/ready handshake. It sits between a byte-wide transport FIFO and consumers that need u64 fields, and replaces the 10-byte-wide parallel unpack where a byte-serial path is available.

## Interface
Parameters: none.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  encoded byte; bit 7 is the continuation (glue) bit, bits 6:0 are the chunk.
- in_valid  in  1  in_data valid.
- in_ready  out  1  decoder accepts in_data this cycle. Combinational: !out_valid || out_ready.
- o  out  64  decoded value; registered.
- len  out  4  bytes consumed for this value, 1..10, saturating at 10; registered.
- err  out  1  value malformed (overflow or too long); registered.
- out_valid  out  1  o/len/err valid.
- out_ready  in  1  consumer accepts output.

## Operation
- Byte accepted when in_valid && in_ready.
- Internal state: acc[63:0], cnt[3:0] (index of next byte, 0..9), ovf flag, state in {COLLECT, SKIP}.
- Byte at index k (k = 0..8) ORs chunk into acc[7k+6:7k]. At k = 0, acc is cleared first, so there is no stale data.
- Index 9 writes chunk bit 0 to acc[63]. Chunk bits 6:1 are overflow bits; if any is nonzero, ovf is set.
- Termination when the accepted byte has bit7 = 0 at k = 0..9:
  - o = acc including this byte.
  - len = k+1.
  - err = ovf.
  - out_valid set; cnt and ovf cleared.
- Too-long case: byte at k = 9 has bit7 = 1. State goes to SKIP with err pending and len = 10.
- SKIP state:
  - Accepted bytes are discarded.
  - The first accepted byte with bit7 = 0 ends the word: o = acc (first 64 bits), len = 10, err = 1, out_valid set.
  - State returns to COLLECT.
- Output handshake: out_valid && out_ready clears out_valid, unless a terminating byte is accepted in the same cycle. In that case out_valid stays 1 and o/len/err load the new value.
- While out_valid && !out_ready:
  - in_ready = 0.
  - o, len and err are held stable.
- Reset values: o = 0, len = 0, err = 0, out_valid = 0, acc = 0, cnt = 0, ovf = 0, state = COLLECT. in_ready = 1 after reset.
- Reset asserted mid-word drops the partial word. No output is produced for it.

## Timing
- Latency: out_valid asserts on the cycle after the terminating byte is accepted.
- Throughput:
  - One byte per cycle.
  - A word of n bytes occupies n input cycles.
  - Back-to-back words need no bubble if out_ready = 1.
- Minimum word-to-word spacing is 1 cycle (single-byte words stream at full rate).
- in_ready has no registered delay. Its only combinational path is out_ready -> in_ready.

## Configuration
- Macro: LEB128_U64_ERR_EN.
- Defined:
  - Overflow and too-long detection are active.
  - The SKIP state exists.
  - err is driven as above.
- Undefined:
  - err is tied to 0 and there is no SKIP state.
  - The byte at k = 9 always terminates the word, regardless of bit7; len = 10.
  - Chunk bits 6:1 at k = 9 are discarded silently.
  - A following byte is decoded as the start of a new word.

## Test plan
- Single byte 0x05, out_ready = 1 -> one cycle later out_valid = 1, o = 5, len = 1, err = 0.
- Bytes 0xE5 0x8E 0x26 -> o = 624485 (0x98765), len = 3, err = 0; the next byte 0x7F back-to-back -> o = 0x7F, len = 1 on the following cycle.
- Nine bytes 0xFF then 0x01 -> o = 0xFFFF_FFFF_FFFF_FFFF, len = 10, err = 0. With 0x03 as the last byte instead:
  - With LEB128_U64_ERR_EN: same o, err = 1.
  - Without it: same o, err = 0.
- With LEB128_U64_ERR_EN: eleven bytes 0x80 then 0x00, then 0x07 -> first output o = 0, len = 10, err = 1; next output o = 7, len = 1, err = 0.
- Backpressure: out_ready = 0 for 5 cycles after word 0x2A completes, with next word 0x81 0x01 pending:
  - in_ready = 0 and o = 0x2A held for all 5 cycles.
  - On release, 0x2A is accepted, then o = 0x81, len = 2.
- Reset asserted after 0xE5 0x8E of a word, then 0x01 -> no output for the partial word; o = 1, len = 1, err = 0.
